// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that locks one requester onto the UartTx data port
// for a whole packet, releasing on the last beat or after an idle timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 9,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_bits,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_valid,
   output logic [DATA_W-1:0]         tx_bits,
   input  logic                      tx_ready,
   output logic [IDX_W-1:0]          grant_idx,
   output logic                      busy,
   output logic                      timeout_evt
);
   localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state, state_nxt;
   logic [IDX_W-1:0] last_grant, grant_nxt, last_nxt, idx;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic evt_nxt, xfer, found;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= IDLE;
         grant_idx   <= '0;
         last_grant  <= IDX_W'(NUM_REQ - 1);
         cnt         <= '0;
         timeout_evt <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant_idx   <= grant_nxt;
         last_grant  <= last_nxt;
         cnt         <= cnt_nxt;
         timeout_evt <= evt_nxt;
      end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_idx;
      last_nxt  = last_grant;
      cnt_nxt   = cnt;
      evt_nxt   = 1'b0;
      found     = 1'b0;
      idx       = '0;
      busy      = state == LOCKED;
      tx_valid  = busy && req_valid[grant_idx];
      tx_bits   = tx_valid ? req_bits[grant_idx*DATA_W +: DATA_W] : '0;
      req_ready = '0;
      req_ready[grant_idx] = busy && tx_ready;
      xfer      = tx_valid && tx_ready;
      if (!busy) begin
         // Search starts just past the last winner so a lone requester wraps back to itself.
         for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req_valid[idx]) begin
               found     = 1'b1;
               grant_nxt = idx;
            end
         end
         state_nxt = found ? LOCKED : IDLE;
         cnt_nxt   = '0;
      end else if (xfer) begin
         cnt_nxt = '0;
         if (req_last[grant_idx]) begin
            state_nxt = IDLE;
            last_nxt  = grant_idx;
         end
      end else if (!req_valid[grant_idx] && TIMEOUT != 0) begin
         // The pulse is registered so it coincides with the first idle cycle.
         if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state_nxt = IDLE;
            last_nxt  = grant_idx;
            evt_nxt   = 1'b1;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic checked against a
// packet-level reference model of the arbiter.
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int W = 9;
   localparam int T = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] req_last = '0;
   logic [N*W-1:0] req_bits = '0;
   logic tx_ready = 1'b0;
   logic [N-1:0] req_ready;
   logic tx_valid, busy, timeout_evt;
   logic [W-1:0] tx_bits;
   logic [1:0] grant_idx;

   int checks = 0;
   int errors = 0;
   bit m_locked, m_evt;
   int m_g, m_last, m_low;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .IDX_W(2), .TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_bits(req_bits),
      .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid), .tx_bits(tx_bits),
      .tx_ready(tx_ready), .grant_idx(grant_idx), .busy(busy), .timeout_evt(timeout_evt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [W-1:0] b, input logic l);
      req_valid[i] = v;
      req_bits[i*W +: W] = b;
      req_last[i] = l;
   endtask

   task automatic model_reset;
      m_locked = 0; m_evt = 0; m_g = 0; m_last = N - 1; m_low = 0;
   endtask

   task automatic check_outputs;
      logic ev;
      logic [W-1:0] eb;
      logic [N-1:0] er;
      ev = m_locked && req_valid[m_g];
      eb = ev ? req_bits[m_g*W +: W] : '0;
      er = (m_locked && tx_ready) ? N'(1 << m_g) : '0;
      chk("m_busy", busy, m_locked);
      chk("m_valid", tx_valid, ev);
      chk("m_bits", tx_bits, eb);
      chk("m_ready", req_ready, er);
      chk("m_grant", grant_idx, m_g);
      chk("m_evt", timeout_evt, m_evt);
   endtask

   // One clock of packet-level behaviour: arbitrate, move beats, or age an idle grant.
   task automatic model_tick;
      m_evt = 0;
      if (!m_locked) begin
         if (|req_valid) begin
            for (int k = 1; k <= N; k++)
               if (req_valid[(m_last + k) % N]) begin
                  m_g = (m_last + k) % N;
                  break;
               end
            m_locked = 1;
            m_low = 0;
         end
      end else if (req_valid[m_g] && tx_ready) begin
         m_low = 0;
         if (req_last[m_g]) begin
            m_locked = 0;
            m_last = m_g;
         end
      end else if (!req_valid[m_g]) begin
         m_low++;
         if (m_low == T) begin
            m_locked = 0;
            m_last = m_g;
            m_evt = 1;
         end
      end
   endtask

   task automatic step;
      #1 check_outputs();
      @(posedge clk);
      if (reset) model_reset(); else model_tick();
      @(negedge clk);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      req_valid = '0; req_last = '0; req_bits = '0; tx_ready = 1'b0;
      model_reset();
      @(negedge clk);
      #1 check_outputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int n, low;
      bit seen;
      int dens;
      @(negedge clk);
      // 1: single beat packet after reset
      do_reset();
      set_req(0, 1, 9'h055, 1); tx_ready = 1;
      #1 chk("t1_bubble", tx_valid, 0);
      step();
      #1 chk("t1_valid", tx_valid, 1);
      chk("t1_bits", tx_bits, 9'h055);
      chk("t1_grant", grant_idx, 0);
      step();
      set_req(0, 0, 0, 0);
      #1 chk("t1_busy", busy, 0);
      step();
      // 2: round robin with all requesters busy
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1, W'(16 + i), 1);
      tx_ready = 1;
      n = 0;
      for (int c = 0; c < 12; c++) begin
         #1 if (tx_valid && tx_ready && n < 6) begin
            chk("t2_order", grant_idx, n % N);
            n++;
         end
         step();
      end
      chk("t2_count", n, 6);
      // 3: multi-beat packet is not preempted
      do_reset();
      set_req(2, 1, 9'h0B2, 1);
      set_req(1, 1, 9'h0A1, 0);
      tx_ready = 1;
      step();
      for (int b = 0; b < 3; b++) begin
         set_req(1, 1, 9'h0A1 + W'(b), b == 2);
         #1 chk("t3_bits", tx_bits, 9'h0A1 + W'(b));
         chk("t3_rdy2", req_ready[2], 0);
         step();
      end
      set_req(1, 0, 0, 0);
      step();
      #1 chk("t3_grant", grant_idx, 2);
      chk("t3_valid", tx_valid, 1);
      step();
      req_valid = '0;
      step();
      // 4: inactivity timeout forces release
      do_reset();
      set_req(3, 1, 9'h011, 0); tx_ready = 1;
      step();
      step();
      set_req(3, 0, 0, 0);
      set_req(0, 1, 9'h0C0, 1);
      low = 0; seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         #1 if (timeout_evt) begin
            seen = 1;
            chk("t4_busy", busy, 0);
         end else if (busy) low++;
         step();
      end
      chk("t4_seen", seen, 1);
      chk("t4_low", low, T);
      #1 chk("t4_pulse", timeout_evt, 0);
      chk("t4_grant", grant_idx, 0);
      chk("t4_busy2", busy, 1);
      step();
      req_valid = '0;
      step();
      // 5: backpressure holds data without timing out
      do_reset();
      set_req(0, 1, 9'h1A5, 0); tx_ready = 0;
      step();
      for (int c = 0; c < 100; c++) begin
         #1 chk("t5_bits", tx_bits, 9'h1A5);
         chk("t5_rdy", req_ready[0], 0);
         chk("t5_evt", timeout_evt, 0);
         step();
      end
      tx_ready = 1; req_last[0] = 1;
      #1 chk("t5_rdy_hi", req_ready[0], 1);
      step();
      req_valid = '0;
      #1 chk("t5_done", busy, 0);
      step();
      // 6: asynchronous reset mid-packet
      do_reset();
      set_req(0, 1, 9'h066, 0); tx_ready = 1;
      step();
      step();
      #2 reset = 1'b1;
      #1 chk("t6_valid", tx_valid, 0);
      chk("t6_ready", req_ready, 0);
      chk("t6_busy", busy, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1, W'(32 + i), 1);
      step();
      #1 chk("t6_grant", grant_idx, 0);
      chk("t6_busy2", busy, 1);
      step();
      // randomized traffic at several request densities
      do_reset();
      for (int p = 0; p < 6; p++) begin
         dens = (p % 3 == 0) ? 60 : (p % 3 == 1) ? 25 : 5;
         for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++)
               set_req(i, $urandom_range(0, 99) < dens, W'($urandom), $urandom_range(0, 2) == 0);
            tx_ready = $urandom_range(0, 3) != 0;
            step();
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
